// File: rtl/rce_pkg.sv
// rtl/rce_pkg.sv - shared types, default widths and Gray helper for ripple_count_extender
package rce_pkg;

   localparam int RCE_CNT_W = 4;
   localparam int RCE_EXT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRED = 2'd2
   } cmp_state_t;

   // Widest supported counter is 32 bits; callers zero-extend and truncate.
   function automatic logic [31:0] gray2bin(input logic [31:0] i_gray);
      logic [31:0] w_bin;
      w_bin[31] = i_gray[31];
      for (int i = 30; i >= 0; i--) begin
         w_bin[i] = w_bin[i+1] ^ i_gray[i];
      end
      return w_bin;
   endfunction

endpackage

// File: rtl/rce_sync.sv
// rtl/rce_sync.sv - multi-flop vector synchroniser for asynchronous inputs
module rce_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_stage [SYNC_STAGES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_extender.sv
// rtl/ripple_count_extender.sv - synchronise, filter and extend a ripple counter with compare interrupt
// Optional: define RCE_GRAY_IN_EN when cnt_in is Gray-coded.
module ripple_count_extender
   import rce_pkg::*;
#(
   parameter int CNT_W       = RCE_CNT_W,
   parameter int EXT_W       = RCE_EXT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CNT_W-1:0]       cnt_in,
   input  logic                   cnt_clr,
   input  logic                   cmp_en,
   input  logic [CNT_W+EXT_W-1:0] cmp_val,
   input  logic                   irq_ack,
   output logic [CNT_W+EXT_W-1:0] count_out,
   output logic                   count_vld,
   output logic                   match_pulse,
   output logic                   match_irq,
   output logic                   overflow
);

   logic [CNT_W-1:0] w_sync_q;
   logic [CNT_W-1:0] w_bin_q;
   logic [CNT_W-1:0] r_prev_q;
   logic [CNT_W-1:0] r_stable;
   logic [EXT_W-1:0] r_ext;
   logic             r_vld;
   logic             r_ovf;
   logic             w_accept;
   logic             w_wrap;
   logic             w_match;
   cmp_state_t       r_state;
   logic             r_pulse;
   logic             r_irq;

   rce_sync #(
      .WIDTH       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (cnt_in),
      .o_q   (w_sync_q)
   );

`ifdef RCE_GRAY_IN_EN
   assign w_bin_q = CNT_W'(gray2bin(32'(w_sync_q)));
`else
   assign w_bin_q = w_sync_q;
`endif

   // Two identical consecutive samples reject mid-ripple transient codes.
   assign w_accept = (w_bin_q == r_prev_q);
   assign w_wrap   = (w_bin_q < r_stable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_q <= '0;
         r_stable <= '0;
         r_ext    <= '0;
         r_vld    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_prev_q <= w_bin_q;
         if (w_accept) begin
            r_stable <= w_bin_q;
         end
         if (cnt_clr) begin
            r_ext <= '0;
            r_ovf <= 1'b0;
            r_vld <= 1'b0;
         end else if (w_accept) begin
            r_vld <= 1'b1;
            if (w_wrap) begin
               if (&r_ext) begin
                  r_ovf <= 1'b1;
               end
               r_ext <= r_ext + 1'b1;
            end
         end
      end
   end

   assign count_out = {r_ext, r_stable};
   assign count_vld = r_vld;
   assign overflow  = r_ovf;
   assign w_match   = r_vld && (count_out == cmp_val);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_pulse <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmp_en) begin
                  r_state <= ARMED;
               end
            end
            ARMED: begin
               if (!cmp_en) begin
                  r_state <= IDLE;
               end else if (w_match) begin
                  r_state <= FIRED;
                  r_pulse <= 1'b1;
                  r_irq   <= 1'b1;
               end
            end
            FIRED: begin
               // Matches are ignored here, including one coinciding with the ack.
               if (irq_ack) begin
                  r_irq   <= 1'b0;
                  r_state <= cmp_en ? ARMED : IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign match_pulse = r_pulse;
   assign match_irq   = r_irq;

endmodule
